// File: rtl/galaga_pkg.sv
// Shared types and helpers for the Galaga player-ship controller.
package galaga_pkg;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

  typedef enum logic {
    SHOT_IDLE = 1'b0,
    SHOT_FLY  = 1'b1
  } shot_state_e;

  // Widest column count the one-hot helper can encode; callers slice down to NPOS.
  localparam int unsigned ONEHOT_MAX = 64;

  function automatic logic [ONEHOT_MAX-1:0] idx_to_onehot(input int unsigned idx);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    if (idx < ONEHOT_MAX) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/galaga_shot_fsm.sv
// Single-shot projectile: launches from the ship column on a FIRE rising edge and climbs ROWS rows.
//   state     | meaning
//   SHOT_IDLE | no shot in flight, row held at 0, column keeps last launch value
//   SHOT_FLY  | shot climbing, one row every SHOT_DIV cycles until hit or top exit
module galaga_shot_fsm
  import galaga_pkg::*;
#(
  parameter int unsigned NPOS     = 8,
  parameter int unsigned ROWS     = 4,
  parameter int unsigned SHOT_DIV = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      fire_i,
  input  logic                      hit_i,
  input  logic [$clog2(NPOS)-1:0]   pos_idx_i,
  output logic                      shot_act_o,
  output logic [$clog2(NPOS)-1:0]   shot_col_o,
  output logic [$clog2(ROWS)-1:0]   shot_row_o,
  output logic                      shot_done_o
);

  localparam int unsigned PW  = $clog2(NPOS);
  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned SW  = (SHOT_DIV > 1) ? $clog2(SHOT_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(SHOT_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  shot_state_e     state_q, state_d;
  logic            fire_q;
  logic [SW-1:0]   step_q, step_d;
  logic [PW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d;
  logic            fire_rise;

  assign fire_rise = fire_i & ~fire_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    case (state_q)
      SHOT_IDLE: begin
        if (fire_rise) begin
          state_d = SHOT_FLY;
          col_d   = pos_idx_i;
          row_d   = '0;
          step_d  = '0;
        end
      end
      SHOT_FLY: begin
        // A hit takes priority over leaving the top on the same edge.
        if (hit_i) begin
          state_d = SHOT_IDLE;
          row_d   = '0;
          step_d  = '0;
        end else if (step_q == STEP_LAST) begin
          step_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = SHOT_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      default: state_d = SHOT_IDLE;
    endcase
  end

  // fire_q resets high so a button held through reset is not taken as a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SHOT_IDLE;
      fire_q  <= 1'b1;
      step_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fire_q  <= fire_i;
      step_q  <= step_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  assign shot_act_o  = (state_q == SHOT_FLY);
  assign shot_col_o  = col_q;
  assign shot_row_o  = row_q;
  assign shot_done_o = done_q;

endmodule

// File: rtl/galaga_ship_ctrl.sv
// Player-ship column tracker with auto-repeat and saturate/wrap edges, plus the shot FSM.
module galaga_ship_ctrl
  import galaga_pkg::*;
#(
  parameter int unsigned NPOS       = 8,
  parameter int unsigned START_POS  = NPOS / 2,
  parameter bit          WRAP       = 1'b0,
  parameter int unsigned REPEAT_DIV = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned SHOT_DIV   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      left_i,
  input  logic                      right_i,
  input  logic                      fire_i,
  input  logic                      hit_i,
  output logic [NPOS-1:0]           pos_o,
  output logic [$clog2(NPOS)-1:0]   pos_idx_o,
  output logic                      shot_act_o,
  output logic [$clog2(NPOS)-1:0]   shot_col_o,
  output logic [$clog2(ROWS)-1:0]   shot_row_o,
  output logic                      shot_done_o
);

  localparam int unsigned PW  = $clog2(NPOS);
  localparam int unsigned RCW = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;
  localparam logic [PW-1:0]  LAST_IDX  = PW'(NPOS - 1);
  localparam logic [PW-1:0]  START_IDX = PW'(START_POS);
  localparam logic [RCW-1:0] REP_LAST  = RCW'(REPEAT_DIV - 1);
  localparam logic [ONEHOT_MAX-1:0] START_OH = idx_to_onehot(START_POS);

  dir_e                  dir, prev_dir_q;
  logic                  step_due;
  logic [RCW-1:0]        rep_cnt_q, rep_cnt_d;
  logic [PW-1:0]         pos_idx_q, pos_idx_d;
  logic [NPOS-1:0]       pos_q, pos_d;
  logic [ONEHOT_MAX-1:0] pos_oh_full;

  always_comb begin
    dir = DIR_NONE;
    if (left_i && !right_i)      dir = DIR_LEFT;
    else if (right_i && !left_i) dir = DIR_RIGHT;
  end

  // New press or reversal moves at once; a held direction waits for the repeat count.
  assign step_due = (dir != DIR_NONE) &&
                    ((dir != prev_dir_q) || (rep_cnt_q == REP_LAST));

  always_comb begin
    pos_idx_d = pos_idx_q;
    rep_cnt_d = rep_cnt_q;
    if (dir == DIR_NONE) begin
      rep_cnt_d = '0;
    end else if (step_due) begin
      rep_cnt_d = '0;
      if (dir == DIR_LEFT) begin
        if (pos_idx_q != '0) pos_idx_d = pos_idx_q - PW'(1);
        else if (WRAP)       pos_idx_d = LAST_IDX;
      end else begin
        if (pos_idx_q != LAST_IDX) pos_idx_d = pos_idx_q + PW'(1);
        else if (WRAP)             pos_idx_d = '0;
      end
    end else begin
      rep_cnt_d = rep_cnt_q + RCW'(1);
    end
    pos_oh_full = idx_to_onehot(32'(pos_idx_d));
    pos_d       = pos_oh_full[NPOS-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_idx_q  <= START_IDX;
      pos_q      <= START_OH[NPOS-1:0];
      rep_cnt_q  <= '0;
      prev_dir_q <= DIR_NONE;
    end else begin
      pos_idx_q  <= pos_idx_d;
      pos_q      <= pos_d;
      rep_cnt_q  <= rep_cnt_d;
      prev_dir_q <= dir;
    end
  end

  assign pos_o     = pos_q;
  assign pos_idx_o = pos_idx_q;

  // The shot latches the registered column, i.e. before any same-edge move.
  galaga_shot_fsm #(
    .NPOS     (NPOS),
    .ROWS     (ROWS),
    .SHOT_DIV (SHOT_DIV)
  ) u_shot (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fire_i      (fire_i),
    .hit_i       (hit_i),
    .pos_idx_i   (pos_idx_q),
    .shot_act_o  (shot_act_o),
    .shot_col_o  (shot_col_o),
    .shot_row_o  (shot_row_o),
    .shot_done_o (shot_done_o)
  );

endmodule

// File: tb/tb_galaga_ship_ctrl.sv
// Scoreboard bench: two controllers (saturating from 4, wrapping from 0) share one random/directed stimulus.
module tb_galaga_ship_ctrl;

  localparam int NPOS = 8;
  localparam int RD   = 4;
  localparam int ROWS = 4;
  localparam int SD   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, left = 1'b0, right = 1'b0, fire = 1'b0, hit = 1'b0;

  logic [7:0] pos0, pos1;
  logic [2:0] idx0, idx1, col0, col1;
  logic [1:0] row0, row1;
  logic       act0, act1, done0, done1;

  galaga_ship_ctrl #(
    .NPOS(NPOS), .START_POS(4), .WRAP(1'b0), .REPEAT_DIV(RD), .ROWS(ROWS), .SHOT_DIV(SD)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .left_i(left), .right_i(right), .fire_i(fire), .hit_i(hit),
    .pos_o(pos0), .pos_idx_o(idx0), .shot_act_o(act0), .shot_col_o(col0),
    .shot_row_o(row0), .shot_done_o(done0)
  );

  galaga_ship_ctrl #(
    .NPOS(NPOS), .START_POS(0), .WRAP(1'b1), .REPEAT_DIV(RD), .ROWS(ROWS), .SHOT_DIV(SD)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .left_i(left), .right_i(right), .fire_i(fire), .hit_i(hit),
    .pos_o(pos1), .pos_idx_o(idx1), .shot_act_o(act1), .shot_col_o(col1),
    .shot_row_o(row1), .shot_done_o(done1)
  );

  // Reference model: ship column, how long the current direction has been held, shot age.
  typedef struct {
    int pos;
    int hdir;
    int hn;
    bit fprev;
    bit fly;
    int age;
    int col;
    bit done;
  } mst_t;

  typedef struct packed {
    logic [7:0] oh;
    logic [2:0] idx;
    logic       act;
    logic [2:0] col;
    logic [1:0] row;
    logic       done;
  } exp_t;

  mst_t m0, m1;
  exp_t q0[$], q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  function automatic mst_t mreset(int start);
    mst_t s;
    s.pos = start; s.hdir = 0; s.hn = 0; s.fprev = 1'b1;
    s.fly = 1'b0; s.age = 0; s.col = 0; s.done = 1'b0;
    return s;
  endfunction

  function automatic mst_t mstep(mst_t s, bit wrap, int start, bit l, bit r, bit f, bit h, bit rs);
    mst_t n;
    int   dir;
    int   tgt;
    bit   go;
    if (rs) return mreset(start);
    n   = s;
    dir = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
    go  = 1'b0;
    if (dir == 0) begin
      n.hdir = 0; n.hn = 0;
    end else if (dir != s.hdir) begin
      n.hdir = dir; n.hn = 0; go = 1'b1;
    end else begin
      n.hn = s.hn + 1;
      go   = ((n.hn % RD) == 0);
    end
    if (go) begin
      tgt = s.pos + dir;
      if (wrap)              n.pos = (tgt + NPOS) % NPOS;
      else if (tgt < 0)      n.pos = 0;
      else if (tgt > NPOS-1) n.pos = NPOS - 1;
      else                   n.pos = tgt;
    end
    n.done = 1'b0;
    if (s.fly) begin
      if (h) n.fly = 1'b0;
      else begin
        n.age = s.age + 1;
        if (n.age == ROWS * SD) begin
          n.fly = 1'b0; n.done = 1'b1;
        end
      end
    end else if (f && !s.fprev) begin
      n.fly = 1'b1; n.age = 0; n.col = s.pos;
    end
    n.fprev = f;
    return n;
  endfunction

  function automatic exp_t mout(mst_t s);
    exp_t e;
    logic [7:0] v;
    v = '0;
    v[s.pos] = 1'b1;
    e.oh   = v;
    e.idx  = 3'(s.pos);
    e.act  = s.fly;
    e.col  = 3'(s.col);
    e.row  = s.fly ? 2'(s.age / SD) : 2'd0;
    e.done = s.done;
    return e;
  endfunction

  task automatic cmp(string nm, int d, logic [31:0] a, logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", nm, d, cyc, a, e);
    end
  endtask

  task automatic drive(bit l, bit r, bit f, bit h, bit rs);
    @(negedge clk);
    left = l; right = r; fire = f; hit = h; rst = rs;
    m0 = mstep(m0, 1'b0, 4, l, r, f, h, rs);
    m1 = mstep(m1, 1'b1, 0, l, r, f, h, rs);
    q0.push_back(mout(m0));
    q1.push_back(mout(m1));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge the DUTs present a new registered state; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("pos_oh", 0, 32'(pos0), 32'(e.oh));
        cmp("pos_idx", 0, 32'(idx0), 32'(e.idx));
        cmp("shot", 0, 32'({act0, col0, row0, done0}), 32'({e.act, e.col, e.row, e.done}));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("pos_oh", 1, 32'(pos1), 32'(e.oh));
        cmp("pos_idx", 1, 32'(idx1), 32'(e.idx));
        cmp("shot", 1, 32'({act1, col1, row1, done1}), 32'({e.act, e.col, e.row, e.done}));
      end
    end
  end

  initial begin
    int nd;
    bit l, r, f, h, rs;
    m0 = mreset(4);
    m1 = mreset(0);

    // Reset with FIRE held: no launch on release.
    repeat (3) drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 0, 0);
    after_edge();
    cmp("reset_pos", 0, 32'(pos0), 32'h10);
    cmp("reset_idx", 0, 32'(idx0), 32'd4);
    cmp("reset_no_fire", 0, 32'(act0), 32'd0);
    drive(0, 0, 0, 0, 0);

    // One-cycle LEFT: saturating unit 4->3, wrapping unit 0->7.
    drive(1, 0, 0, 0, 0);
    after_edge();
    cmp("wrap_left_oh", 1, 32'(pos1), 32'h80);
    cmp("wrap_left_idx", 1, 32'(idx1), 32'd7);
    drive(0, 0, 0, 0, 0);

    // Fire at column 3, second press mid-flight is dropped.
    drive(0, 0, 1, 0, 0);
    after_edge();
    cmp("fire_act", 0, 32'(act0), 32'd1);
    cmp("fire_col", 0, 32'(col0), 32'd3);
    nd = 0;
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, (i == 3), 0, 0);
      after_edge();
      if (done0) nd++;
    end
    cmp("done_once", 0, 32'(nd), 32'd1);

    // Hold LEFT, then switch straight to RIGHT.
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    after_edge();
    cmp("reverse_idx", 0, 32'(idx0), 32'd3);
    drive(0, 0, 0, 0, 0);

    // Hit at row 2, then relaunch from a new column.
    drive(0, 0, 1, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    after_edge();
    cmp("row_before_hit", 0, 32'(row0), 32'd2);
    drive(0, 0, 0, 1, 0);
    after_edge();
    cmp("hit_act", 0, 32'(act0), 32'd0);
    repeat (10) drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    after_edge();
    cmp("relaunch_col", 0, 32'(col0), 32'd4);
    repeat (10) drive(0, 0, 0, 0, 0);

    // Hold RIGHT from 4: 5, 6, 7 then saturate; both buttons hold.
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 0, 0);
    after_edge();
    cmp("hold_right_idx", 0, 32'(idx0), 32'd7);
    repeat (6) drive(0, 1, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 0, 0);
    after_edge();
    cmp("both_hold_idx", 0, 32'(idx0), 32'd7);

    // Reset mid-flight with RIGHT held through it.
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 1);
    after_edge();
    cmp("rst_shot", 0, 32'({act0, row0, done0}), 32'd0);
    drive(0, 1, 0, 0, 0);
    after_edge();
    cmp("rst_held_move", 0, 32'(idx0), 32'd5);

    // Random phase with sticky buttons.
    l = 0; r = 0; f = 0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) f = ~f;
      h  = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 199) == 0);
      drive(l, r, f, h, rs);
    end

    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    cmp("queue_drained", 0, 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
